// File: rtl/wb_ctrl_pkg.sv
// Shared types and constants for the write-back controller.
package wb_pkg;

  localparam int NUM_REGS = 16;
  localparam int CTRL_REG = 13;

  // One queued write request
  typedef struct packed {
    logic [3:0] rd;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       is_mul;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    STALL
  } wb_state_t;

  // One-hot register mask for a 4-bit register index
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [3:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Bus bundle between the execute/memory producers and the write-back controller.
interface wb_ctrl_if;
  import wb_pkg::*;

  logic                ld_valid;
  logic                ld_ready;
  logic [3:0]          ld_rd;
  logic [7:0]          ld_data;

  logic                mul_valid;
  logic                mul_ready;
  logic [3:0]          mul_rd;
  logic [7:0]          mul_lo;
  logic [7:0]          mul_hi;

  logic                alu_valid;
  logic                alu_ready;
  logic [3:0]          alu_rd;
  logic [7:0]          alu_data;

  logic                wb_stall;

  logic [7:0]          d;
  logic [7:0]          mult_high;
  logic [NUM_REGS-1:0] en_n;
  logic [NUM_REGS-1:0] pending;
  logic                idle;

  // Controller side
  modport slave (
    input  ld_valid, ld_rd, ld_data,
    input  mul_valid, mul_rd, mul_lo, mul_hi,
    input  alu_valid, alu_rd, alu_data,
    input  wb_stall,
    output ld_ready, mul_ready, alu_ready,
    output d, mult_high, en_n, pending, idle
  );

  // Producer / register-file side
  modport master (
    output ld_valid, ld_rd, ld_data,
    output mul_valid, mul_rd, mul_lo, mul_hi,
    output alu_valid, alu_rd, alu_data,
    output wb_stall,
    input  ld_ready, mul_ready, alu_ready,
    input  d, mult_high, en_n, pending, idle
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries; head is visible combinationally
// so the controller can launch a strobe on the same edge it pops.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  wb_entry_t                i_entry,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Entry storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates ld > mul > alu, queues requests and issues
// one single-cycle register-file write strobe per cycle.
// Optional feature macro: WB_SCOREBOARD_EN builds the per-register pending scoreboard.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MULT_REG = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  wb_ctrl_if.slave bus
);

  localparam int         CNTW = $clog2(DEPTH) + 1;
  localparam logic [3:0] MR   = 4'(MULT_REG);

  wb_state_t           r_state;
  wb_state_t           w_state_next;
  logic                r_out_en;
  logic [NUM_REGS-1:0] r_en_n;
  logic [7:0]          r_d;
  logic [7:0]          r_mult_high;
  logic                r_idle;

  logic                w_full;
  logic                w_empty;
  logic [CNTW-1:0]     w_count;
  logic [CNTW-1:0]     w_count_next;
  wb_entry_t           w_head;
  wb_entry_t           w_new_entry;
  wb_entry_t           w_src;

  logic                w_ld_ready;
  logic                w_mul_ready;
  logic                w_alu_ready;
  logic                w_acc_ld;
  logic                w_acc_mul;
  logic                w_acc_alu;
  logic                w_accept;
  logic                w_launch;
  logic                w_bypass;
  logic                w_pop;
  logic                w_push_fifo;

  logic [NUM_REGS-1:0] w_en_n_next;
  logic [7:0]          w_d_next;
  logic [7:0]          w_mh_next;

  // Readys are held low until the first edge after reset release
  assign w_ld_ready  = r_out_en & ~w_full;
  assign w_mul_ready = r_out_en & ~w_full & ~bus.ld_valid;
  assign w_alu_ready = r_out_en & ~w_full & ~bus.ld_valid & ~bus.mul_valid;

  assign w_acc_ld  = bus.ld_valid  & w_ld_ready;
  assign w_acc_mul = bus.mul_valid & w_mul_ready;
  assign w_acc_alu = bus.alu_valid & w_alu_ready;
  assign w_accept  = w_acc_ld | w_acc_mul | w_acc_alu;

  assign bus.ld_ready  = w_ld_ready;
  assign bus.mul_ready = w_mul_ready;
  assign bus.alu_ready = w_alu_ready;
  assign bus.en_n      = r_en_n;
  assign bus.d         = r_d;
  assign bus.mult_high = r_mult_high;
  assign bus.idle      = r_idle;

  // Build the entry for whichever producer wins arbitration this cycle
  always_comb begin
    w_new_entry = '0;
    if (w_acc_ld) begin
      w_new_entry.rd = bus.ld_rd;
      w_new_entry.lo = bus.ld_data;
    end else if (w_acc_mul) begin
      w_new_entry.rd     = bus.mul_rd;
      w_new_entry.lo     = bus.mul_lo;
      w_new_entry.hi     = bus.mul_hi;
      w_new_entry.is_mul = 1'b1;
    end else if (w_acc_alu) begin
      w_new_entry.rd = bus.alu_rd;
      w_new_entry.lo = bus.alu_data;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_fifo),
    .i_entry (w_new_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and issue decisions; an accept into an empty queue launches directly
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_bypass     = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && !bus.wb_stall) begin
          w_launch = 1'b1;
          w_bypass = 1'b1;
        end
      end
      ISSUE, STALL: begin
        if (!bus.wb_stall && !w_empty) begin
          w_launch = 1'b1;
          w_pop    = 1'b1;
        end
      end
      default: ;
    endcase
    w_push_fifo  = w_accept & ~w_bypass;
    w_count_next = w_count + CNTW'(w_push_fifo) - CNTW'(w_pop);
    if (w_count_next == '0)  w_state_next = IDLE;
    else if (bus.wb_stall)   w_state_next = STALL;
    else                     w_state_next = ISSUE;
  end

  // Strobe decode: MULT_REG only ever loads from mult_high
  always_comb begin
    w_src       = w_bypass ? w_new_entry : w_head;
    w_en_n_next = '1;
    w_d_next    = r_d;
    w_mh_next   = r_mult_high;
    if (w_launch) begin
      if (w_src.rd == MR) begin
        w_en_n_next[MR] = 1'b0;
        w_mh_next       = w_src.is_mul ? w_src.hi : w_src.lo;
      end else begin
        w_en_n_next[w_src.rd] = 1'b0;
        w_d_next              = w_src.lo;
        if (w_src.is_mul) begin
          w_en_n_next[MR] = 1'b0;
          w_mh_next       = w_src.hi;
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_n      <= '1;
      r_d         <= '0;
      r_mult_high <= '0;
      r_idle      <= 1'b1;
      r_out_en    <= 1'b0;
    end else begin
      r_en_n      <= w_en_n_next;
      r_d         <= w_d_next;
      r_mult_high <= w_mh_next;
      r_idle      <= (w_count_next == '0) && !w_launch;
      r_out_en    <= 1'b1;
    end
  end

`ifdef WB_SCOREBOARD_EN
  // Scoreboard: a write is in flight from its accept edge until its strobe ends
  localparam int SW = $clog2(DEPTH + 2);

  logic [NUM_REGS-1:0] w_inc_mask;
  logic [NUM_REGS-1:0] w_dec_mask;
  logic [NUM_REGS-1:0] w_pending;

  assign w_inc_mask = w_accept ? (reg_onehot(w_new_entry.rd) |
                                  (w_new_entry.is_mul ? reg_onehot(MR) : '0))
                               : '0;
  assign w_dec_mask = ~r_en_n;
  assign bus.pending = w_pending;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    logic [SW-1:0] r_cnt;
    logic [SW-1:0] w_cnt_next;
    logic          r_pend;

    assign w_cnt_next   = r_cnt + SW'(w_inc_mask[gi]) - SW'(w_dec_mask[gi]);
    assign w_pending[gi] = r_pend;

    // Per-register in-flight write counter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_pend <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_next;
        r_pend <= (w_cnt_next != '0);
      end
    end
  end
`else
  assign bus.pending = '0;
`endif

endmodule
